// File: rtl/display_pkg.sv
// Definitions shared by the display pipeline: default bus widths and the
// address generator's state encoding.
package display_pkg;
    localparam int DEF_ADDR_W = 20;
    localparam int DEF_X_W    = 11;
    localparam int DEF_Y_W    = 10;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } fag_state_t;
endpackage

// File: rtl/raster_counter.sv
// Column/line counters for a raster walk with terminal-count flags for the
// last pixel of a line and of a frame.
module raster_counter
    import display_pkg::*;
#(
    parameter int X_W = DEF_X_W,
    parameter int Y_W = DEF_Y_W
) (
    input  logic           clk,
    input  logic           rst_ni,
    input  logic           clr_i,
    input  logic           adv_i,
    input  logic [X_W-1:0] h_act_i,
    input  logic [Y_W-1:0] v_act_i,
    output logic [X_W-1:0] pix_x_o,
    output logic [Y_W-1:0] pix_y_o,
    output logic           line_tc_o,
    output logic           frame_tc_o
);
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    assign line_tc_o  = (x_q == h_act_i - X_W'(1));
    assign frame_tc_o = line_tc_o && (y_q == v_act_i - Y_W'(1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (adv_i) begin
            if (line_tc_o) begin
                x_d = '0;
                y_d = frame_tc_o ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign pix_x_o = x_q;
    assign pix_y_o = y_q;
endmodule

// File: rtl/frame_addr_gen.sv
// Framebuffer address generator: walks a strided 2-D window in raster order
// with double-buffered bases, frame-synchronous swap and stop.
module frame_addr_gen
    import display_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int X_W    = DEF_X_W,
    parameter int Y_W    = DEF_Y_W
) (
    input  logic              clk,
    input  logic              ResetN,
    input  logic              Start,
    input  logic              Stop,
    input  logic              IncAddr,
    input  logic              SwapReq,
    input  logic [ADDR_W-1:0] Base0,
    input  logic [ADDR_W-1:0] Base1,
    input  logic [ADDR_W-1:0] Stride,
    input  logic [X_W-1:0]    HActive,
    input  logic [Y_W-1:0]    VActive,
    output logic [ADDR_W-1:0] Addr,
    output logic [X_W-1:0]    PixX,
    output logic [Y_W-1:0]    PixY,
    output logic              LineEnd,
    output logic              FrameEnd,
    output logic              ActiveBuf,
    output logic              Busy
);
    fag_state_t        state_q;
    logic [ADDR_W-1:0] addr_q, line_base_q, stride_q;
    logic [X_W-1:0]    h_q;
    logic [Y_W-1:0]    v_q;
    logic              active_buf_q, swap_pend_q, stop_pend_q;
    logic              line_end_q, frame_end_q, busy_q;

    logic              start_ok, adv, line_tc, frame_tc;
    logic              buf_d, stop_eff;
    logic [ADDR_W-1:0] base_d, next_line_base;

    assign start_ok = (state_q == IDLE) && Start && (HActive != '0) && (VActive != '0);
    assign adv      = (state_q == SCAN) && IncAddr;

    // A request arriving on the boundary cycle itself still applies to it.
    assign buf_d          = active_buf_q ^ (swap_pend_q | SwapReq);
    assign stop_eff       = stop_pend_q | Stop;
    assign base_d         = buf_d ? Base1 : Base0;
    assign next_line_base = line_base_q + stride_q;

    raster_counter #(
        .X_W(X_W),
        .Y_W(Y_W)
    ) u_raster (
        .clk       (clk),
        .rst_ni    (ResetN),
        .clr_i     (start_ok),
        .adv_i     (adv),
        .h_act_i   (h_q),
        .v_act_i   (v_q),
        .pix_x_o   (PixX),
        .pix_y_o   (PixY),
        .line_tc_o (line_tc),
        .frame_tc_o(frame_tc)
    );

    always_ff @(posedge clk) begin
        if (!ResetN) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            line_base_q  <= '0;
            stride_q     <= '0;
            h_q          <= '0;
            v_q          <= '0;
            active_buf_q <= 1'b0;
            swap_pend_q  <= 1'b0;
            stop_pend_q  <= 1'b0;
            line_end_q   <= 1'b0;
            frame_end_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            if (SwapReq) swap_pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        h_q          <= HActive;
                        v_q          <= VActive;
                        stride_q     <= Stride;
                        active_buf_q <= buf_d;
                        swap_pend_q  <= 1'b0;
                        addr_q       <= base_d;
                        line_base_q  <= base_d;
                        busy_q       <= 1'b1;
                        state_q      <= SCAN;
                    end
                end
                SCAN: begin
                    if (Stop) stop_pend_q <= 1'b1;
                    if (IncAddr) begin
                        if (!line_tc) begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end else if (!frame_tc) begin
                            line_base_q <= next_line_base;
                            addr_q      <= next_line_base;
                            line_end_q  <= 1'b1;
                        end else begin
                            line_end_q   <= 1'b1;
                            frame_end_q  <= 1'b1;
                            active_buf_q <= buf_d;
                            swap_pend_q  <= 1'b0;
                            h_q          <= HActive;
                            v_q          <= VActive;
                            stride_q     <= Stride;
                            addr_q       <= base_d;
                            line_base_q  <= base_d;
                            if (stop_eff) begin
                                stop_pend_q <= 1'b0;
                                busy_q      <= 1'b0;
                                state_q     <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Addr      = addr_q;
    assign LineEnd   = line_end_q;
    assign FrameEnd  = frame_end_q;
    assign ActiveBuf = active_buf_q;
    assign Busy      = busy_q;
endmodule
